// File: rtl/jpc_pcgen_if.sv
// Fetch-PC offer, redirect and status bundle between jpc_pcgen and its neighbours.
// master = the PC generator, slave = the fetch/branch side.
interface jpc_pcgen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic [ADDR_WIDTH-1:0] pc_O;
  logic                  pc_valid_O;
  logic                  pc_ready_I;
  logic [ADDR_WIDTH-1:0] redir_pc_I;
  logic                  redir_valid_I;
  logic                  redir_ready_O;
  logic                  halt_I;
  logic                  halted_O;
  logic                  fault_O;
  logic [CNT_WIDTH-1:0]  issue_cnt_O;

  modport master (
    output pc_O, pc_valid_O, redir_ready_O, halted_O, fault_O, issue_cnt_O,
    input  pc_ready_I, redir_pc_I, redir_valid_I, halt_I
  );

  modport slave (
    input  pc_O, pc_valid_O, redir_ready_O, halted_O, fault_O, issue_cnt_O,
    output pc_ready_I, redir_pc_I, redir_valid_I, halt_I
  );
endinterface

// File: rtl/jpc_pcgen.sv
// Fetch program-counter generator: offers the PC on valid/ready, advances by 4,
// takes branch redirects (deferred while an offer is outstanding), halts and faults.
module jpc_pcgen #(
  parameter int                    ADDR_WIDTH   = 32,  // JPC_ADDRESS_WIDTH
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    CNT_WIDTH    = 32
) (
  input logic         clk,
  input logic         rst_n,
  jpc_pcgen_if.master bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_HALT, ST_FAULT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  fault_q, fault_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic redir_ready, redir_hs, redir_ok, redir_bad, pc_hs;

  // fault_q covers both FAULT and an offer still held while heading into FAULT
  assign redir_ready = ~pend_valid_q & ~fault_q;
  assign redir_hs    = bus.redir_valid_I & redir_ready;
  assign redir_bad   = redir_hs & (bus.redir_pc_I[1:0] != 2'b00);
  assign redir_ok    = redir_hs & ~redir_bad;
  assign pc_hs       = (state_q == ST_ISSUE) & bus.pc_ready_I;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_VECTOR;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      fault_q      <= fault_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    fault_d      = fault_q | redir_bad;
    cnt_d        = cnt_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (redir_ok) pc_d = bus.redir_pc_I;
        if (redir_bad)       state_d = ST_FAULT;
        else if (bus.halt_I) state_d = (state_q == ST_IDLE) ? ST_HALT : ST_HALT;
        else                 state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (pc_hs) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (redir_ok) begin
            pc_d = bus.redir_pc_I;
          end else if (pend_valid_q) begin
            pc_d         = pend_pc_q;
            pend_valid_d = 1'b0;
          end else begin
            pc_d = pc_q + ADDR_WIDTH'(4);
          end
          if (fault_q | redir_bad) state_d = ST_FAULT;
          else if (bus.halt_I)     state_d = ST_HALT;
        end else if (redir_ok) begin
          // current offer must stay stable, so the target waits one handshake
          pend_pc_d    = bus.redir_pc_I;
          pend_valid_d = 1'b1;
        end
      end
      default: state_d = ST_FAULT;
    endcase
  end

  assign bus.pc_O          = pc_q;
  assign bus.pc_valid_O    = (state_q == ST_ISSUE);
  assign bus.redir_ready_O = redir_ready;
  assign bus.halted_O      = (state_q == ST_HALT);
  assign bus.fault_O       = fault_q;
  assign bus.issue_cnt_O   = cnt_q;
endmodule

// File: tb/tb_jpc_pcgen.sv
// Directed table-driven bench for jpc_pcgen, plus hand sequences for reset and fault corners.
module tb_jpc_pcgen;
  logic clk;
  logic rst_n;

  jpc_pcgen_if #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) bus ();
  jpc_pcgen_if #(.ADDR_WIDTH(32), .CNT_WIDTH(2))  sbus ();

  jpc_pcgen #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h100), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // small-counter instance, free running, to exercise issue_cnt wrap
  jpc_pcgen #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        rv;
    logic        halt;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic        e_v;
    logic        e_rr;
    logic        e_h;
    logic        e_f;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic ready, input logic rv, input logic halt, input logic [31:0] rpc,
                     input logic [31:0] e_pc, input logic e_v, input logic e_rr, input logic e_h,
                     input logic e_f, input logic [31:0] e_cnt);
    vec_t v;
    v.ready = ready; v.rv = rv; v.halt = halt; v.rpc = rpc;
    v.e_pc = e_pc; v.e_v = e_v; v.e_rr = e_rr; v.e_h = e_h; v.e_f = e_f; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [127:0] outs();
    return {60'd0, bus.pc_O, bus.pc_valid_O, bus.redir_ready_O, bus.halted_O, bus.fault_O, bus.issue_cnt_O};
  endfunction

  function automatic logic [127:0] pack(input logic [31:0] pc, input logic v, input logic rr,
                                        input logic h, input logic f, input logic [31:0] cnt);
    return {60'd0, pc, v, rr, h, f, cnt};
  endfunction

  task automatic drive(input logic ready, input logic rv, input logic [31:0] rpc, input logic halt);
    bus.pc_ready_I    = ready;
    bus.redir_valid_I = rv;
    bus.redir_pc_I    = rpc;
    bus.halt_I        = halt;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    sbus.pc_ready_I = 1'b1; sbus.redir_valid_I = 1'b0; sbus.redir_pc_I = 32'h0; sbus.halt_I = 1'b0;

    //      rdy  rv   halt rpc            | pc            v    rr   h    f    cnt
    add(1'b1, 1'b0, 1'b0, 32'h0,        32'h100,      1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    add(1'b1, 1'b0, 1'b0, 32'h0,        32'h100,      1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    add(1'b1, 1'b0, 1'b0, 32'h0,        32'h104,      1'b1, 1'b1, 1'b0, 1'b0, 32'd1);
    add(1'b1, 1'b0, 1'b0, 32'h0,        32'h108,      1'b1, 1'b1, 1'b0, 1'b0, 32'd2);
    add(1'b0, 1'b1, 1'b0, 32'h400,      32'h10C,      1'b1, 1'b1, 1'b0, 1'b0, 32'd3);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h10C,      1'b1, 1'b0, 1'b0, 1'b0, 32'd3);
    add(1'b1, 1'b0, 1'b0, 32'h0,        32'h10C,      1'b1, 1'b0, 1'b0, 1'b0, 32'd3);
    add(1'b1, 1'b1, 1'b0, 32'h200,      32'h400,      1'b1, 1'b1, 1'b0, 1'b0, 32'd4);
    add(1'b1, 1'b1, 1'b0, 32'h800,      32'h200,      1'b1, 1'b1, 1'b0, 1'b0, 32'd5);
    add(1'b1, 1'b1, 1'b0, 32'h300,      32'h800,      1'b1, 1'b1, 1'b0, 1'b0, 32'd6);
    add(1'b0, 1'b0, 1'b1, 32'h0,        32'h300,      1'b1, 1'b1, 1'b0, 1'b0, 32'd7);
    add(1'b1, 1'b0, 1'b1, 32'h0,        32'h300,      1'b1, 1'b1, 1'b0, 1'b0, 32'd7);
    add(1'b1, 1'b1, 1'b1, 32'h40,       32'h304,      1'b0, 1'b1, 1'b1, 1'b0, 32'd8);
    add(1'b0, 1'b0, 1'b0, 32'h0,        32'h40,       1'b0, 1'b1, 1'b1, 1'b0, 32'd8);
    add(1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h40,       1'b1, 1'b1, 1'b0, 1'b0, 32'd8);
    add(1'b1, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 1'b0, 32'd9);
    add(1'b0, 1'b1, 1'b0, 32'h402,      32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'd10);
    add(1'b0, 1'b1, 1'b0, 32'h500,      32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'd10);
    add(1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'd10);
    add(1'b1, 1'b0, 1'b0, 32'h0,        32'h4,        1'b0, 1'b0, 1'b0, 1'b1, 32'd11);
    add(1'b1, 1'b1, 1'b0, 32'h800,      32'h4,        1'b0, 1'b0, 1'b0, 1'b1, 32'd11);

    repeat (2) @(negedge clk);
    #1 check("reset_values", outs(), pack(32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      logic [1:0]  s_cnt;
      logic [31:0] s_pc;
      drive(vecs[i].ready, vecs[i].rv, vecs[i].rpc, vecs[i].halt);
      #1;
      check($sformatf("row%0d", i), outs(),
            pack(vecs[i].e_pc, vecs[i].e_v, vecs[i].e_rr, vecs[i].e_h, vecs[i].e_f, vecs[i].e_cnt));
      s_cnt = (i == 0) ? 2'd0 : 2'((i - 1) % 4);
      s_pc  = (i == 0) ? 32'h0 : 32'(4 * (i - 1));
      check($sformatf("small_row%0d", i),
            {92'd0, sbus.pc_O, sbus.pc_valid_O, sbus.issue_cnt_O},
            {92'd0, s_pc, (i > 0), s_cnt});
      @(negedge clk);
    end

    // asynchronous reset from FAULT clears everything
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1 check("reset_clears_fault", outs(), pack(32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h900, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1 check("pend_before_reset", outs(), pack(32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
    rst_n = 1'b0;
    #1 check("reset_mid_pending", outs(), pack(32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("post_reset_offer%0d", k), outs(),
               pack(32'h100 + 32'(4 * k), 1'b1, 1'b1, 1'b0, 1'b0, 32'(k)));
      @(negedge clk);
    end

    // misaligned redirect coinciding with a PC handshake: handshake still counts
    #1 check("pre_mis_coincident", outs(), pack(32'h10C, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3));
    drive(1'b1, 1'b1, 32'h6, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    #1 check("mis_coincident", outs(), pack(32'h110, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4));
    @(negedge clk);
    #1 check("fault_sticky", outs(), pack(32'h110, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
